// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, exception bits.
// No logic of its own; helper function is purely combinational.
// Range checking in the top is controlled by macro LSU_RANGE_CHECK_EN.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } req_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  localparam int EXC_MISALIGN = 0;
  localparam int EXC_RANGE    = 1;

  typedef struct packed {
    logic        write;
    req_size_e   size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic is_misaligned(input req_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; operands are held stable by the owning FSM.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  req_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    sh        = {addr_lo, 3'b000};
    shifted   = rd_word >> sh;
    load_data = rd_word;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << sh;
      end
      SIZE_HALF: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << sh;
      end
      default: ;
    endcase
    // A full word store sees an all-ones mask and so ignores the stale read word.
    store_word = (rd_word & ~lane_mask) | ((wdata << sh) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide DM (LSU_RANGE_CHECK_EN adds range exceptions).
// Latency: Resp_Valid 1 (exception), 2 (load / word store) or 3 (sub-word store) cycles after accept.
// Backpressure: Stall holds the pipeline from the accept cycle until the response cycle.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int DM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Unsigned,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Stall,
  output logic        Resp_Valid,
  output logic [31:0] Resp_RData,
  output logic [1:0]  Resp_Exc,
  output logic        DM_R_Enable,
  output logic        DM_W_Enable,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_W_data,
  input  logic [31:0] DM_R_data
);

  localparam logic [29:0] IDX_MASK = 30'(DM_DEPTH - 1);

  lsu_state_e  state, state_nxt;
  lsu_req_t    req_q;
  logic [1:0]  exc_q;
  logic [31:0] rd_word_q;
  logic [1:0]  exc_in;
  logic        sub_word_in;
  logic [31:0] load_data;
  logic [31:0] store_word;

  always_comb begin
    exc_in = 2'b00;
    exc_in[EXC_MISALIGN] = is_misaligned(req_size_e'(Req_Size), Req_Addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
    exc_in[EXC_RANGE] = ({2'b00, Req_Addr[31:2]} >= 32'(DM_DEPTH));
`endif
    sub_word_in = (req_size_e'(Req_Size) != SIZE_WORD);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Req_Valid) begin
          if (exc_in != 2'b00)               state_nxt = RESP;
          else if (!Req_Write || sub_word_in) state_nxt = READ;
          else                                state_nxt = WRITE;
        end
      end
      // Only sub-word stores reach READ with write set: read-modify-write.
      READ:    state_nxt = req_q.write ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      exc_q     <= 2'b00;
      rd_word_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Req_Valid) begin
        req_q <= '{write:       Req_Write,
                   size:        req_size_e'(Req_Size),
                   is_unsigned: Req_Unsigned,
                   addr:        Req_Addr,
                   wdata:       Req_WData};
        exc_q <= exc_in;
      end
      if (state == READ) rd_word_q <= DM_R_data;
    end
  end

  lsu_lane_align u_lane_align (
    .rd_word     (rd_word_q),
    .addr_lo     (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .wdata       (req_q.wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    Stall       = (state == IDLE && Req_Valid) || state == READ || state == WRITE;
    Resp_Valid  = (state == RESP);
    Resp_Exc    = (state == RESP) ? exc_q : 2'b00;
    Resp_RData  = (state == RESP && !req_q.write && exc_q == 2'b00) ? load_data : 32'h0;
    // Strobes are gated by rst so a reset landing on WRITE never corrupts DM.
    DM_R_Enable = (state == READ) && !rst;
    DM_W_Enable = (state == WRITE) && !rst;
    DM_Addr     = (state == READ || state == WRITE) ? {2'b00, req_q.addr[31:2] & IDX_MASK} : 32'h0;
    DM_W_data   = (state == WRITE) ? store_word : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences and random traffic
// checked against a byte-addressed memory model.
module tb_load_store_unit;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  exc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req_Valid, Req_Write, Req_Unsigned;
  logic [1:0]  Req_Size;
  logic [31:0] Req_Addr, Req_WData;
  logic        Stall, Resp_Valid;
  logic [31:0] Resp_RData;
  logic [1:0]  Resp_Exc;
  logic        DM_R_Enable, DM_W_Enable;
  logic [31:0] DM_Addr, DM_W_data, DM_R_data;

  logic [31:0] dm [DEPTH];
  logic        preload_go;
  logic [7:0]  mdl [DEPTH*4];
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  load_store_unit #(.DM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Write(Req_Write), .Req_Size(Req_Size),
    .Req_Unsigned(Req_Unsigned), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
    .Stall(Stall), .Resp_Valid(Resp_Valid), .Resp_RData(Resp_RData), .Resp_Exc(Resp_Exc),
    .DM_R_Enable(DM_R_Enable), .DM_W_Enable(DM_W_Enable), .DM_Addr(DM_Addr),
    .DM_W_data(DM_W_data), .DM_R_data(DM_R_data)
  );

  function automatic logic [31:0] preload_val(input int i);
    case (i)
      2:       return 32'h11223344;
      3:       return 32'h00008F00;
      4:       return 32'h80017FFE;
      5:       return 32'hCAFEBABE;
      default: return 32'h5A5A0000 ^ (32'(i) * 32'h01030507);
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= preload_val(i);
    end else if (DM_W_Enable) begin
      dm[DM_Addr[AW-1:0]] <= DM_W_data;
    end
  end

  assign DM_R_data = dm[DM_Addr[AW-1:0]];

  // ---------------- reference model ----------------
  function automatic logic [1:0] mdl_exc(input logic [1:0] size, input logic [31:0] a);
    logic [1:0] e;
    e = 2'b00;
    if (size == 2'b11) e[0] = 1'b1;
    else if ((a % (32'd1 << size)) != 0) e[0] = 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if ((a >> 2) >= 32'(DEPTH)) e[1] = 1'b1;
`endif
    return e;
  endfunction

  function automatic int mdl_lat(input logic wr, input logic [1:0] size, input logic [1:0] e);
    if (e != 2'b00) return 1;
    if (!wr || size == 2'b10) return 2;
    return 3;
  endfunction

  function automatic int mdl_base(input logic [31:0] a);
    return int'(((a >> 2) % DEPTH) * 4 + (a % 4));
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns, input logic [31:0] a);
    logic [63:0] v;
    int n, b;
    v = 64'd0;
    n = 1 << size;
    b = mdl_base(a);
    for (int i = 0; i < n; i++) v = v | (64'(mdl[b + i]) << (8 * i));
    if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    int n, b;
    n = 1 << size;
    b = mdl_base(a);
    for (int i = 0; i < n; i++) mdl[b + i] = 8'(d >> (8 * i));
  endtask

  function automatic int mem_diff();
    int cnt;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dm[i] !== {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]}) cnt++;
    return cnt;
  endfunction

  function automatic vec_t mkv(input string name, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, input logic [31:0] rdata, input logic [1:0] exc);
    vec_t v;
    v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata; v.exc = exc;
    return v;
  endfunction

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  // Issue one request and watch it until Resp_Valid (bounded), counting strobes and protocol slips.
  task automatic run_req(input vec_t v, input logic [31:0] exp_idx,
                         output int lat, output logic [31:0] rdata, output logic [1:0] exc,
                         output int nrd, output int nwr, output int bad);
    lat = -1; rdata = '0; exc = '0; nrd = 0; nwr = 0; bad = 0;
    @(posedge clk); #1;
    Req_Valid = 1'b1; Req_Write = v.wr; Req_Size = v.size; Req_Unsigned = v.uns;
    Req_Addr = v.addr; Req_WData = v.wdata;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (DM_R_Enable) nrd++;
      if (DM_W_Enable) nwr++;
      if ((DM_R_Enable || DM_W_Enable) && DM_Addr !== exp_idx) bad++;
      if (!DM_R_Enable && !DM_W_Enable && DM_Addr !== 32'h0) bad++;
      if (!DM_W_Enable && DM_W_data !== 32'h0) bad++;
      if (Resp_Valid) begin
        lat = c; rdata = Resp_RData; exc = Resp_Exc;
        if (Stall) bad++;
      end else begin
        if (!Stall) bad++;
        if (Resp_Exc !== 2'b00 || Resp_RData !== 32'h0) bad++;
      end
      @(posedge clk); #1;
      Req_Valid = 1'b0; Req_Write = 1'($urandom_range(0, 1)); Req_Size = 2'($urandom_range(0, 3));
      Req_Unsigned = 1'($urandom_range(0, 1)); Req_Addr = $urandom(); Req_WData = $urandom();
    end
  endtask

  task automatic do_txn(input vec_t v);
    int lat, nrd, nwr, bad, e_nrd, e_nwr;
    logic [31:0] rdata, idx;
    logic [1:0] exc, mexc;
    mexc  = mdl_exc(v.size, v.addr);
    e_nrd = (mexc == 2'b00 && (!v.wr || v.size != 2'b10)) ? 1 : 0;
    e_nwr = (mexc == 2'b00 && v.wr) ? 1 : 0;
    idx   = (v.addr >> 2) % DEPTH;
    run_req(v, idx, lat, rdata, exc, nrd, nwr, bad);
    if (e_nwr == 1) mdl_store(v.size, v.addr, v.wdata);
    check(v.name, "latency", lat, v.lat);
    check(v.name, "rdata", rdata, v.rdata);
    check(v.name, "exc", {30'd0, exc}, {30'd0, v.exc});
    check(v.name, "dm_reads", nrd, e_nrd);
    check(v.name, "dm_writes", nwr, e_nwr);
    check(v.name, "protocol", bad, 0);
    check(v.name, "mem_words_wrong", mem_diff(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ea, eb, ra, rb;
    int pulses, c1, c2;
    vec_t rv;

    rst = 1'b1; preload_go = 1'b0;
    Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'b00; Req_Unsigned = 1'b0;
    Req_Addr = '0; Req_WData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", "Stall", Stall, 0);
    check("reset", "Resp_Valid", Resp_Valid, 0);
    check("reset", "Resp_RData", Resp_RData, 0);
    check("reset", "Resp_Exc", Resp_Exc, 0);
    check("reset", "DM_R_Enable", DM_R_Enable, 0);
    check("reset", "DM_W_Enable", DM_W_Enable, 0);
    check("reset", "DM_Addr", DM_Addr, 0);
    check("reset", "DM_W_data", DM_W_data, 0);

    @(posedge clk); #1 preload_go = 1'b1;
    @(posedge clk); #1 preload_go = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = preload_val(i);
      for (int j = 0; j < 4; j++) mdl[4*i+j] = 8'(w >> (8 * j));
    end

    vecs.push_back(mkv("ld_b_s_0D",   0, 2'b00, 0, 32'h0D, 0,            2, 32'hFFFFFF8F, 2'b00));
    vecs.push_back(mkv("ld_b_u_0D",   0, 2'b00, 1, 32'h0D, 0,            2, 32'h0000008F, 2'b00));
    vecs.push_back(mkv("ld_h_s_12",   0, 2'b01, 0, 32'h12, 0,            2, 32'hFFFF8001, 2'b00));
    vecs.push_back(mkv("ld_h_s_10",   0, 2'b01, 0, 32'h10, 0,            2, 32'h00007FFE, 2'b00));
    vecs.push_back(mkv("ld_w_14",     0, 2'b10, 0, 32'h14, 0,            2, 32'hCAFEBABE, 2'b00));
    vecs.push_back(mkv("st_h_0A",     1, 2'b01, 0, 32'h0A, 32'h1234BEEF, 3, 32'h0,        2'b00));
    vecs.push_back(mkv("ld_w_08",     0, 2'b10, 0, 32'h08, 0,            2, 32'hBEEF3344, 2'b00));
    vecs.push_back(mkv("st_b_17",     1, 2'b00, 0, 32'h17, 32'hFFFFFF5A, 3, 32'h0,        2'b00));
    vecs.push_back(mkv("ld_w_14b",    0, 2'b10, 1, 32'h14, 0,            2, 32'h5AFEBABE, 2'b00));
    vecs.push_back(mkv("st_w_0C",     1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 2, 32'h0,        2'b00));
    vecs.push_back(mkv("ld_b_s_0F",   0, 2'b00, 0, 32'h0F, 0,            2, 32'hFFFFFFDE, 2'b00));
    vecs.push_back(mkv("mis_ld_w_06", 0, 2'b10, 0, 32'h06, 0,            1, 32'h0,        2'b01));
    vecs.push_back(mkv("mis_st_h_0B", 1, 2'b01, 0, 32'h0B, 32'h0000FFFF, 1, 32'h0,        2'b01));
    vecs.push_back(mkv("ill_size_00", 0, 2'b11, 0, 32'h00, 0,            1, 32'h0,        2'b01));
`ifdef LSU_RANGE_CHECK_EN
    vecs.push_back(mkv("range_ld_80", 0, 2'b10, 0, 32'h80, 0,            1, 32'h0,        2'b10));
    vecs.push_back(mkv("range_mis_81",0, 2'b10, 0, 32'h81, 0,            1, 32'h0,        2'b11));
`else
    vecs.push_back(mkv("wrap_ld_80",  0, 2'b10, 0, 32'h80, 0,            2, 32'h5A5A0000, 2'b00));
`endif
    foreach (vecs[k]) do_txn(vecs[k]);

    // Reset landing on the WRITE cycle of a byte store.
    @(posedge clk); #1;
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b00; Req_Unsigned = 1'b0;
    Req_Addr = 32'h11; Req_WData = 32'h77;
    @(posedge clk); #1 Req_Valid = 1'b0;
    @(negedge clk);
    check("rst_wr", "read_strobe", DM_R_Enable, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_wr", "DM_W_Enable", DM_W_Enable, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr", "Stall", Stall, 0);
    check("rst_wr", "Resp_Valid", Resp_Valid, 0);
    check("rst_wr", "DM_Addr", DM_Addr, 0);
    check("rst_wr", "mem_words_wrong", mem_diff(), 0);
    do_txn(mkv("post_rst_ld_10", 0, 2'b10, 0, 32'h10, 0, 2, 32'h80017FFE, 2'b00));

    // Back-to-back loads with Req_Valid held through RESP.
    ea = mdl_load(2'b10, 1'b0, 32'h14);
    eb = mdl_load(2'b00, 1'b1, 32'h08);
    ra = '0; rb = '0; pulses = 0; c1 = -1; c2 = -1;
    @(posedge clk); #1;
    Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'b10; Req_Unsigned = 1'b0; Req_Addr = 32'h14;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (Resp_Valid) begin
        pulses++;
        if (c1 < 0) begin c1 = c; ra = Resp_RData; end
        else begin c2 = c; rb = Resp_RData; end
      end
      @(posedge clk); #1;
      if (c == 0) begin Req_Size = 2'b00; Req_Unsigned = 1'b1; Req_Addr = 32'h08; end
      if (c == 3) Req_Valid = 1'b0;
    end
    check("b2b", "pulses", pulses, 2);
    check("b2b", "first_resp_cycle", c1, 2);
    check("b2b", "second_resp_cycle", c2, 5);
    check("b2b", "first_rdata", ra, ea);
    check("b2b", "second_rdata", rb, eb);

    // Random traffic against the model.
    for (int k = 0; k < 150; k++) begin
      rv.name  = $sformatf("rand%0d", k);
      rv.wr    = 1'($urandom_range(0, 1));
      rv.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rv.uns   = 1'($urandom_range(0, 1));
      rv.addr  = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      if ($urandom_range(0, 7) == 0) rv.addr = rv.addr | ($urandom() & 32'hFFFF_FF80);
      rv.wdata = $urandom();
      rv.exc   = mdl_exc(rv.size, rv.addr);
      rv.lat   = mdl_lat(rv.wr, rv.size, rv.exc);
      rv.rdata = (rv.wr || rv.exc != 2'b00) ? 32'h0 : mdl_load(rv.size, rv.uns, rv.addr);
      do_txn(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
